// File: rtl/pc_target_pkg.sv
// Shared constants and next-PC select encoding for the PC target unit.
// The return-address stack is enabled by defining PC_TARGET_RAS_EN.
package pc_target_pkg;

  localparam int PC_W_DEF      = 32;
  localparam int OFF_W_DEF     = 8;
  localparam int SHIFT_DEF     = 2;
  localparam int RAS_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_TGT = 2'd1,
    SEL_RAS = 2'd2
  } next_sel_e;

  // Any source other than the sequential address counts as a redirect.
  function automatic logic sel_is_redirect(input next_sel_e sel);
    return (sel != SEL_SEQ);
  endfunction

endpackage

// File: rtl/pc_target_unit_ret_addr_stack.sv
// Circular return-address stack: the write pointer and the fill count are kept separately,
// so a push onto a full stack overwrites the oldest entry while the count stays at DEPTH.
module ret_addr_stack
  import pc_target_pkg::*;
#(
  parameter int W     = PC_W_DEF,
  parameter int DEPTH = RAS_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_top,
  output logic         o_empty,
  output logic         o_full,
  output logic         o_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_err;

  assign o_empty = (r_count == CNT_W'(0));
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_top   = r_mem[r_ptr - PTR_W'(1)];
  assign o_err   = r_err;

  // Entry storage; the contents need no reset because a zero count hides them.
  always_ff @(posedge clk) begin
    if (resetn && i_push && !i_pop) begin
      r_mem[r_ptr] <= i_data;
    end
  end

  // Pointer, count and error pulse; pop wins if both requests arrive together.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ptr   <= PTR_W'(0);
      r_count <= CNT_W'(0);
      r_err   <= 1'b0;
    end else if (i_pop) begin
      if (o_empty) begin
        r_err <= 1'b1;
      end else begin
        r_ptr   <= r_ptr - PTR_W'(1);
        r_count <= r_count - CNT_W'(1);
        r_err   <= 1'b0;
      end
    end else if (i_push) begin
      r_ptr <= r_ptr + PTR_W'(1);
      if (!o_full) begin
        r_count <= r_count + CNT_W'(1);
      end
      r_err <= o_full;
    end else begin
      r_err <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_target_unit.sv
// Program-counter target unit: sequential, PC-relative and return-stack next-PC selection.
// Define PC_TARGET_RAS_EN to build the return-address stack; otherwise CALL acts as JUMP.
module pc_target_unit
  import pc_target_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int OFF_W     = OFF_W_DEF,
  parameter int SHIFT     = SHIFT_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             STALL,
  input  logic             JUMP,
  input  logic             BRANCH,
  input  logic             ZERO,
  input  logic             CALL,
  input  logic             RET,
  input  logic [OFF_W-1:0] OFFSET,
  output logic [PC_W-1:0]  PC,
  output logic             REDIRECT,
  output logic             RAS_EMPTY,
  output logic             RAS_FULL,
  output logic             RAS_ERR
);

  logic [PC_W-1:0] r_pc;
  logic            r_redirect;
  logic [PC_W-1:0] w_seq;
  logic [PC_W-1:0] w_off_ext;
  logic [PC_W-1:0] w_tgt;
  logic [PC_W-1:0] w_ras_top;
  next_sel_e       w_sel;

  assign w_seq     = r_pc + PC_W'(4);
  assign w_off_ext = {{(PC_W - OFF_W){OFFSET[OFF_W-1]}}, OFFSET};
  assign w_tgt     = w_seq + (w_off_ext << SHIFT);

`ifdef PC_TARGET_RAS_EN
  logic w_push;
  logic w_pop;
  logic w_ras_empty;
  logic w_ras_full;
  logic w_ras_err;

  // Priority RET > CALL > JUMP > taken branch; RET on an empty stack still pops to flag the error.
  always_comb begin
    w_sel  = SEL_SEQ;
    w_push = 1'b0;
    w_pop  = 1'b0;
    if (RET) begin
      w_pop = 1'b1;
      if (!w_ras_empty) begin
        w_sel = SEL_RAS;
      end else begin
        w_sel = SEL_SEQ;
      end
    end else if (CALL) begin
      w_sel  = SEL_TGT;
      w_push = 1'b1;
    end else if (JUMP || (BRANCH && ZERO)) begin
      w_sel = SEL_TGT;
    end else begin
      w_sel = SEL_SEQ;
    end
  end

  ret_addr_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (CLK),
    .resetn  (RESETN),
    .i_push  (w_push && !STALL),
    .i_pop   (w_pop && !STALL),
    .i_data  (w_seq),
    .o_top   (w_ras_top),
    .o_empty (w_ras_empty),
    .o_full  (w_ras_full),
    .o_err   (w_ras_err)
  );

  assign RAS_EMPTY = w_ras_empty;
  assign RAS_FULL  = w_ras_full;
  assign RAS_ERR   = w_ras_err;
`else
  logic w_unused_ret;

  assign w_unused_ret = RET;
  assign w_ras_top    = w_seq;

  // Without a stack, CALL is a plain jump and RET is ignored.
  always_comb begin
    w_sel = SEL_SEQ;
    if (CALL || JUMP || (BRANCH && ZERO)) begin
      w_sel = SEL_TGT;
    end else begin
      w_sel = SEL_SEQ;
    end
  end

  assign RAS_EMPTY = 1'b1;
  assign RAS_FULL  = 1'b0;
  assign RAS_ERR   = 1'b0;
`endif

  // PC register and redirect flag; reset overrides stall and every request.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_pc       <= PC_W'(0);
      r_redirect <= 1'b0;
    end else if (STALL) begin
      r_redirect <= 1'b0;
    end else begin
      r_redirect <= sel_is_redirect(w_sel);
      case (w_sel)
        SEL_SEQ: r_pc <= w_seq;
        SEL_TGT: r_pc <= w_tgt;
        SEL_RAS: r_pc <= w_ras_top;
        default: r_pc <= w_seq;
      endcase
    end
  end

  assign PC       = r_pc;
  assign REDIRECT = r_redirect;

endmodule
